pool_relu: RTL and testbench
============================

// Module: pool_relu
// PURPOSE
//  Downstream stage of the convolution engine: reads finished conv output maps (signed Q16.16) from DRAM.
//  Applies ReLU and 2x2/stride-2 max pooling, then writes each pooled map back to DRAM.
//  Shares the DRAM port protocol of the conv stage. The top-level sequencer starts it with enable once conv asserts done.
// PARAMETERS
//  DATA_WIDTH  32       word width, signed Q16.16
//  ADDR_WIDTH  18       DRAM word address width
//  IFMAP_W     28       input map width (words); odd -> last column ignored
//  IFMAP_H     28       input map height; odd -> last row ignored
//  NUM_CHNL    6        channels to pool
//  IN_BASE     18'd0    DRAM address of channel 0, pixel (0,0) of input maps
//  OUT_BASE    18'd4704 DRAM address of first pooled word
// PORTS
//  clk         in   1           clock, rising edge
//  rst         in   1           asynchronous reset, active-high
//  enable      in   1           level; high = run, low = abort/idle
//  dram_valid  in   1           read data on data_in valid this cycle
//  data_in     in   DATA_WIDTH  DRAM read data
//  data_out    out  DATA_WIDTH  pooled result to DRAM
//  addr_in     out  ADDR_WIDTH  DRAM read address
//  addr_out    out  ADDR_WIDTH  DRAM write address
//  dram_en_rd  out  1           read request
//  dram_en_wr  out  1           write strobe, one cycle per pooled word
//  done        out  1           all channels written
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; counters and max register cleared.
//  FSM: IDLE -> RD (enable=1 and done=0)
//       RD: dram_en_rd=1, addr_in=window address k (k=0..3 as (0,0),(0,1),(1,0),(1,1))
//           capture data_in only on a dram_valid cycle; k++; k=3 captured -> WR.
//           addr_in holds until dram_valid.
//       WR: dram_en_wr=1 for exactly one cycle; data_out=max; addr_out=OUT_BASE+out_cnt.
//           Last pixel of last channel -> DONE, else -> RD with next window.
//       DONE: done=1 held while enable=1; enable=0 -> IDLE, done=0.
//  enable low in RD/WR: next cycle IDLE, counters cleared, no write issued.
//  Restart always begins from channel 0.
//  Read address: IN_BASE + ch*IFMAP_W*IFMAP_H + (2r+dy)*IFMAP_W + 2c+dx.
//  Write address: OUT_BASE + linear out_cnt, 0..NUM_CHNL*(IFMAP_W/2)*(IFMAP_H/2)-1.
//  Scan order: c fastest, then r, then ch.
//  Max register reloads to 0 at window start, so result = max(0,a,b,c,d) (ReLU fused).
//  Signed compare on full DATA_WIDTH; no rounding, no saturation needed.
//  Per-window cost: 4 reads (>=4 cycles, 1/dram_valid) + 1 write cycle.
//  dram_valid outside RD: ignored. dram_en_rd and dram_en_wr are never high together.
//  Async rst mid-operation: immediate return to reset state; partial window discarded.
// STRUCTURE
//  Shared package cnn_pkg:
//   - DATA_WIDTH, ADDR_WIDTH
//   - Q16.16 constants (Q_FRAC=16, Q_ZERO)
//   - DRAM port typedef
//   - pool FSM state enum {IDLE,RD,WR,DONE}
//  Sub-module pool_addr_gen:
//   - c/r/ch/k/out_cnt counters
//   - address arithmetic; flags last_k, last_win
//  pool_relu owns the FSM, the max register and the output registers.
// TESTING
//  1) 4x4x1 map, values 1..16 (Q16.16), dram_valid every cycle
//     -> 4 writes: 6,8,14,16 (<<16) at OUT_BASE+0..3; done high after last write.
//  2) All-negative window (-1,-2,-3,-4) -> written value 0.
//     Mixed window (-5,0x00008000,-1,-2) -> 0x00008000.
//  3) dram_valid asserted every 3rd cycle -> addr_in stable between valids.
//     Same results as (1); exactly 4 dram_valid per write.
//  4) 5x5x2 map (odd size) -> 8 writes total.
//     Column 4 and row 4 addresses never appear on addr_in.
//     Channel 1 reads start at IN_BASE+25.
//  5) Drop enable in the middle of window 2 -> no write that window, IDLE next cycle.
//     Re-enable -> restart at channel 0, addr_in=IN_BASE.
//  6) Async rst pulse during WR -> dram_en_wr, done, data_out 0 without a clock edge.
//     Default 28x28x6 run -> 1176 writes, done set.

Source files
------------

// File: rtl/cnn_pkg.sv
// cnn_pkg: definitions shared by the CNN pipeline stages.
// Holds the default DRAM word/address widths, the Q16.16 number format
// constants, the DRAM request bundle and the pooling FSM state encoding.
package cnn_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 18;

    // Q16.16 fixed point: 16 fraction bits; zero doubles as the ReLU floor.
    localparam int Q_FRAC = 16;
    localparam logic signed [DATA_WIDTH-1:0] Q_ZERO = '0;

    // One cycle's worth of DRAM port activity driven by a pipeline stage.
    typedef struct packed {
        logic                  rd_en;
        logic                  wr_en;
        logic [ADDR_WIDTH-1:0] rd_addr;
        logic [ADDR_WIDTH-1:0] wr_addr;
        logic [DATA_WIDTH-1:0] wr_data;
    } dram_req_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } pool_state_e;

endpackage

// File: rtl/pool_addr_gen.sv
// pool_addr_gen: window/channel counters and DRAM address arithmetic for
// the 2x2 stride-2 pooling stage.
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   clear_i           return every counter to the first window of channel 0
//   capture_i         one window element was read, step to the next one
//   nextWin_i         the pooled word was written, step to the next window
//   rdAddr_o          read address of the current window element
//   wrAddr_o          write address of the current pooled word
//   firstK_o          current element is the first of its window
//   lastK_o           current element is the last of its window
//   lastWin_o         current window is the last window of the last channel
module pool_addr_gen #(
    parameter int                    ADDR_WIDTH = 18,
    parameter int                    IFMAP_W    = 28,
    parameter int                    IFMAP_H    = 28,
    parameter int                    NUM_CHNL   = 6,
    parameter logic [ADDR_WIDTH-1:0] IN_BASE    = '0,
    parameter logic [ADDR_WIDTH-1:0] OUT_BASE   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_i,
    input  logic                  capture_i,
    input  logic                  nextWin_i,
    output logic [ADDR_WIDTH-1:0] rdAddr_o,
    output logic [ADDR_WIDTH-1:0] wrAddr_o,
    output logic                  firstK_o,
    output logic                  lastK_o,
    output logic                  lastWin_o
);

    // Odd map sizes simply drop the trailing column/row via the division.
    localparam logic [ADDR_WIDTH-1:0] LAST_COL  = ADDR_WIDTH'(IFMAP_W / 2 - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW  = ADDR_WIDTH'(IFMAP_H / 2 - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_CH   = ADDR_WIDTH'(NUM_CHNL - 1);
    localparam logic [ADDR_WIDTH-1:0] ROW_WORDS = ADDR_WIDTH'(IFMAP_W);
    localparam logic [ADDR_WIDTH-1:0] MAP_WORDS = ADDR_WIDTH'(IFMAP_W * IFMAP_H);

    logic [1:0]            k_q, k_d;
    logic [ADDR_WIDTH-1:0] col_q, col_d;
    logic [ADDR_WIDTH-1:0] row_q, row_d;
    logic [ADDR_WIDTH-1:0] ch_q, ch_d;
    logic [ADDR_WIDTH-1:0] outCnt_q, outCnt_d;
    logic [ADDR_WIDTH-1:0] rowIdx, colIdx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q      <= '0;
            col_q    <= '0;
            row_q    <= '0;
            ch_q     <= '0;
            outCnt_q <= '0;
        end else begin
            k_q      <= k_d;
            col_q    <= col_d;
            row_q    <= row_d;
            ch_q     <= ch_d;
            outCnt_q <= outCnt_d;
        end
    end

    // k wraps 3->0 on its own, so after the fourth capture it already points
    // at the first element of the following window. Column runs fastest,
    // then row, then channel.
    always_comb begin
        k_d      = k_q;
        col_d    = col_q;
        row_d    = row_q;
        ch_d     = ch_q;
        outCnt_d = outCnt_q;
        if (clear_i) begin
            k_d      = '0;
            col_d    = '0;
            row_d    = '0;
            ch_d     = '0;
            outCnt_d = '0;
        end else begin
            if (capture_i) begin
                k_d = k_q + 2'd1;
            end
            if (nextWin_i) begin
                outCnt_d = outCnt_q + ADDR_WIDTH'(1);
                if (col_q == LAST_COL) begin
                    col_d = '0;
                    if (row_q == LAST_ROW) begin
                        row_d = '0;
                        ch_d  = (ch_q == LAST_CH) ? '0 : ch_q + ADDR_WIDTH'(1);
                    end else begin
                        row_d = row_q + ADDR_WIDTH'(1);
                    end
                end else begin
                    col_d = col_q + ADDR_WIDTH'(1);
                end
            end
        end
    end

    // k[1] selects the lower row of the window, k[0] the right column.
    always_comb begin
        rowIdx    = (row_q << 1) | ADDR_WIDTH'(k_q[1]);
        colIdx    = (col_q << 1) | ADDR_WIDTH'(k_q[0]);
        rdAddr_o  = IN_BASE + ch_q * MAP_WORDS + rowIdx * ROW_WORDS + colIdx;
        wrAddr_o  = OUT_BASE + outCnt_q;
        firstK_o  = (k_q == 2'd0);
        lastK_o   = (k_q == 2'd3);
        lastWin_o = (col_q == LAST_COL) && (row_q == LAST_ROW) && (ch_q == LAST_CH);
    end

endmodule

// File: rtl/pool_relu.sv
// pool_relu: reads finished conv maps (signed Q16.16) from DRAM, applies
// ReLU and 2x2/stride-2 max pooling, and writes each pooled word back.
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   enable       level; high runs the stage, low aborts or idles it
//   dram_valid   data_in carries the requested read word this cycle
//   data_in      DRAM read data
//   data_out     pooled word, valid while dram_en_wr is high
//   addr_in      DRAM read address
//   addr_out     DRAM write address
//   dram_en_rd   read request
//   dram_en_wr   write strobe, one cycle per pooled word
//   done         every channel has been written; held while enable stays high
module pool_relu #(
    parameter int                    DATA_WIDTH = cnn_pkg::DATA_WIDTH,
    parameter int                    ADDR_WIDTH = cnn_pkg::ADDR_WIDTH,
    parameter int                    IFMAP_W    = 28,
    parameter int                    IFMAP_H    = 28,
    parameter int                    NUM_CHNL   = 6,
    parameter logic [ADDR_WIDTH-1:0] IN_BASE    = '0,
    parameter logic [ADDR_WIDTH-1:0] OUT_BASE   = ADDR_WIDTH'(4704)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  dram_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ADDR_WIDTH-1:0] addr_in,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic                  dram_en_rd,
    output logic                  dram_en_wr,
    output logic                  done
);

    import cnn_pkg::*;

    pool_state_e                  state_q, state_d;
    logic signed [DATA_WIDTH-1:0] max_q, max_d;
    logic signed [DATA_WIDTH-1:0] maxBase;
    logic                         clearCnt, captureK, nextWin;
    logic [ADDR_WIDTH-1:0]        rdAddr, wrAddr;
    logic                         firstK, lastK, lastWin;
    dram_req_t                    req;

    pool_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .IFMAP_W    (IFMAP_W),
        .IFMAP_H    (IFMAP_H),
        .NUM_CHNL   (NUM_CHNL),
        .IN_BASE    (IN_BASE),
        .OUT_BASE   (OUT_BASE)
    ) addrGen (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (clearCnt),
        .capture_i (captureK),
        .nextWin_i (nextWin),
        .rdAddr_o  (rdAddr),
        .wrAddr_o  (wrAddr),
        .firstK_o  (firstK),
        .lastK_o   (lastK),
        .lastWin_o (lastWin)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            max_q   <= Q_ZERO;
        end else begin
            state_q <= state_d;
            max_q   <= max_d;
        end
    end

    // The first element of every window is compared against zero rather
    // than the stale maximum, which fuses ReLU into the pooling.
    always_comb begin
        state_d  = state_q;
        max_d    = max_q;
        clearCnt = 1'b0;
        captureK = 1'b0;
        nextWin  = 1'b0;
        maxBase  = firstK ? Q_ZERO : max_q;
        case (state_q)
            IDLE: begin
                clearCnt = 1'b1;
                max_d    = Q_ZERO;
                if (enable) begin
                    state_d = RD;
                end
            end
            RD: begin
                if (!enable) begin
                    state_d  = IDLE;
                    clearCnt = 1'b1;
                    max_d    = Q_ZERO;
                end else if (dram_valid) begin
                    captureK = 1'b1;
                    max_d    = ($signed(data_in) > maxBase) ? $signed(data_in) : maxBase;
                    if (lastK) begin
                        state_d = WR;
                    end
                end
            end
            WR: begin
                if (!enable) begin
                    state_d  = IDLE;
                    clearCnt = 1'b1;
                    max_d    = Q_ZERO;
                end else begin
                    nextWin = 1'b1;
                    state_d = lastWin ? DONE : RD;
                end
            end
            DONE: begin
                if (!enable) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode straight from the state register so an async reset
    // silences the port immediately. The write is gated by enable so an
    // abort during WR never reaches DRAM.
    always_comb begin
        req = '0;
        if (state_q == RD) begin
            req.rd_en   = 1'b1;
            req.rd_addr = rdAddr;
        end
        if (state_q == WR && enable) begin
            req.wr_en   = 1'b1;
            req.wr_addr = wrAddr;
            req.wr_data = max_q;
        end
    end

    assign dram_en_rd = req.rd_en;
    assign dram_en_wr = req.wr_en;
    assign addr_in    = req.rd_addr;
    assign addr_out   = req.wr_addr;
    assign data_out   = req.wr_data;
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_pool_relu.sv
// tb_pool_relu: directed bench for pool_relu. Three instances cover a 4x4x1
// map, an odd 5x5x2 map and the default 28x28x6 configuration, each backed
// by a small DRAM model that answers reads when the shared valid phase hits.
module tb_pool_relu;

    localparam logic [17:0] OUT_BASE = 18'd4704;
    localparam logic [31:0] JUNK     = 32'h7FFF_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   period = 1;
    int   phase  = 0;
    int   checkCount = 0;
    int   passCount  = 0;

    always #5 clk = ~clk;

    // Shared read-latency pattern: a read is answered only on phase 0.
    always @(posedge clk) phase <= (phase + 1 >= period) ? 0 : phase + 1;

    // ---------------- instance A: 4x4x1 ----------------
    logic        enA, validA, rdA, wrA, doneA;
    logic [31:0] dataA, dataOutA;
    logic [17:0] addrInA, addrOutA;
    logic [31:0] memA [16];
    logic [31:0] wrDataA [$];
    logic [17:0] wrAddrA [$];
    int          vcAtWrA [$];
    int          validSinceWrA = 0, validTotalA = 0, unstableA = 0, overlapA = 0;
    logic        prevRdA = 1'b0, prevValidA = 1'b0;
    logic [17:0] prevAddrA = '0;

    assign validA = rdA && (phase == 0);
    always_comb begin
        dataA = JUNK;
        if (validA && int'(addrInA) < 16) dataA = memA[int'(addrInA)];
    end

    pool_relu #(.IFMAP_W(4), .IFMAP_H(4), .NUM_CHNL(1)) dutA (
        .clk(clk), .rst(rst), .enable(enA), .dram_valid(validA), .data_in(dataA),
        .data_out(dataOutA), .addr_in(addrInA), .addr_out(addrOutA),
        .dram_en_rd(rdA), .dram_en_wr(wrA), .done(doneA)
    );

    always @(negedge clk) begin
        if (wrA) begin
            wrDataA.push_back(dataOutA);
            wrAddrA.push_back(addrOutA);
            vcAtWrA.push_back(validSinceWrA);
        end
        validSinceWrA <= wrA ? 0 : validSinceWrA + (validA ? 1 : 0);
        validTotalA   <= validTotalA + (validA ? 1 : 0);
        if (rdA && prevRdA && !prevValidA && addrInA != prevAddrA) unstableA <= unstableA + 1;
        if (rdA && wrA) overlapA <= overlapA + 1;
        prevRdA    <= rdA;
        prevValidA <= validA;
        prevAddrA  <= addrInA;
    end

    // ---------------- instance B: 5x5x2 ----------------
    logic        enB, validB, rdB, wrB, doneB;
    logic [31:0] dataB, dataOutB;
    logic [17:0] addrInB, addrOutB;
    logic [31:0] memB [50];
    logic [31:0] wrDataB [$];
    logic [17:0] wrAddrB [$];
    logic [17:0] rdLogB [$];
    int          badAddrB = 0;

    assign validB = rdB && (phase == 0);
    always_comb begin
        dataB = JUNK;
        if (validB && int'(addrInB) < 50) dataB = memB[int'(addrInB)];
    end

    pool_relu #(.IFMAP_W(5), .IFMAP_H(5), .NUM_CHNL(2)) dutB (
        .clk(clk), .rst(rst), .enable(enB), .dram_valid(validB), .data_in(dataB),
        .data_out(dataOutB), .addr_in(addrInB), .addr_out(addrOutB),
        .dram_en_rd(rdB), .dram_en_wr(wrB), .done(doneB)
    );

    always @(negedge clk) begin
        if (wrB) begin
            wrDataB.push_back(dataOutB);
            wrAddrB.push_back(addrOutB);
        end
        if (validB) rdLogB.push_back(addrInB);
        if (rdB && ((int'(addrInB) % 5) == 4 || ((int'(addrInB) % 25) / 5) == 4))
            badAddrB <= badAddrB + 1;
    end

    // ---------------- instance C: default 28x28x6 ----------------
    logic        enC, validC, rdC, wrC, doneC;
    logic [31:0] dataC, dataOutC;
    logic [17:0] addrInC, addrOutC;
    logic [31:0] memC [4704];
    logic [31:0] expC [$];
    logic [31:0] wrDataC [$];
    logic [17:0] wrAddrC [$];
    int          overlapC = 0;

    assign validC = rdC && (phase == 0);
    always_comb begin
        dataC = JUNK;
        if (validC && int'(addrInC) < 4704) dataC = memC[int'(addrInC)];
    end

    pool_relu dutC (
        .clk(clk), .rst(rst), .enable(enC), .dram_valid(validC), .data_in(dataC),
        .data_out(dataOutC), .addr_in(addrInC), .addr_out(addrOutC),
        .dram_en_rd(rdC), .dram_en_wr(wrC), .done(doneC)
    );

    always @(negedge clk) begin
        if (wrC) begin
            wrDataC.push_back(dataOutC);
            wrAddrC.push_back(addrOutC);
        end
        if (rdC && wrC) overlapC <= overlapC + 1;
    end

    // ---------------- helpers ----------------
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    endtask

    // Waits on negedges for done (which 0/1/2 = A/B/C) or a write on A (which 3).
    task automatic waitFor(input int which, input int budget, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            case (which)
                0: hit = doneA;
                1: hit = doneB;
                2: hit = doneC;
                default: hit = wrA;
            endcase
        end
    endtask

    task automatic applyStimulus(input int which);
        bit hit;
        waitFor(which, 12000, hit);
        checkOutput($sformatf("timeout_%0d", which), 32'(hit), 32'd1);
    endtask

    task automatic fillCountA();
        for (int i = 0; i < 16; i++) memA[i] = 32'(i + 1) << 16;
    endtask

    task automatic checkFourA(input string tag, input int base, input logic [31:0] e0,
                              input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] exp4 [4];
        exp4 = '{e0, e1, e2, e3};
        checkOutput({tag, "_count"}, 32'(wrDataA.size() - base), 32'd4);
        for (int i = 0; i < 4 && base + i < wrDataA.size(); i++) begin
            checkOutput($sformatf("%s_data%0d", tag, i), wrDataA[base + i], exp4[i]);
            checkOutput($sformatf("%s_addr%0d", tag, i), 32'(wrAddrA[base + i]), 32'(OUT_BASE) + 32'(i));
        end
    endtask

    initial begin
        int          base, vBase, n;
        bit          hit;
        logic signed [31:0] m, v;
        enA = 1'b0; enB = 1'b0; enC = 1'b0;
        fillCountA();
        for (int i = 0; i < 50; i++) memB[i] = 32'(i) << 16;
        for (int i = 0; i < 4704; i++) memC[i] = $urandom;
        for (int ch = 0; ch < 6; ch++)
            for (int r = 0; r < 14; r++)
                for (int c = 0; c < 14; c++) begin
                    m = 0;
                    for (int d = 0; d < 4; d++) begin
                        v = memC[ch * 784 + (2 * r + d / 2) * 28 + 2 * c + d % 2];
                        if (v > m) m = v;
                    end
                    expC.push_back(m);
                end

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_rd", 32'(rdA), 32'd0);
        checkOutput("rst_wr", 32'(wrA), 32'd0);
        checkOutput("rst_done", 32'(doneA), 32'd0);
        checkOutput("rst_dout", dataOutA, 32'd0);
        checkOutput("rst_ain", 32'(addrInA), 32'd0);
        checkOutput("rst_aout", 32'(addrOutA), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1) 4x4x1 ascending map, valid every cycle
        $display("[TB] test 1: 4x4x1 ascending");
        base = wrDataA.size();
        enA = 1'b1;
        applyStimulus(0);
        checkFourA("t1", base, 32'h0006_0000, 32'h0008_0000, 32'h000E_0000, 32'h0010_0000);
        checkOutput("t1_done", 32'(doneA), 32'd1);
        enA = 1'b0;
        @(negedge clk);
        checkOutput("t1_done_clear", 32'(doneA), 32'd0);

        // 2) ReLU floor on an all-negative window, small positive fraction wins
        $display("[TB] test 2: negative and mixed windows");
        memA[0] = -32'sd1; memA[1] = -32'sd2; memA[4] = -32'sd3; memA[5] = -32'sd4;
        memA[2] = -32'sd5; memA[3] = 32'h0000_8000; memA[6] = -32'sd1; memA[7] = -32'sd2;
        for (int i = 8; i < 16; i++) memA[i] = 32'(i) << 16;
        base = wrDataA.size();
        enA = 1'b1;
        applyStimulus(0);
        checkFourA("t2", base, 32'h0000_0000, 32'h0000_8000, 32'h000D_0000, 32'h000F_0000);
        enA = 1'b0;
        @(negedge clk);

        // 3) valid every third cycle
        $display("[TB] test 3: sparse dram_valid");
        fillCountA();
        period = 3;
        base  = wrDataA.size();
        vBase = validTotalA;
        n     = unstableA;
        enA = 1'b1;
        applyStimulus(0);
        checkFourA("t3", base, 32'h0006_0000, 32'h0008_0000, 32'h000E_0000, 32'h0010_0000);
        checkOutput("t3_addr_hold", 32'(unstableA - n), 32'd0);
        checkOutput("t3_valid_total", 32'(validTotalA - vBase), 32'd16);
        for (int i = 0; i < 4 && base + i < vcAtWrA.size(); i++)
            checkOutput($sformatf("t3_valid_per_wr%0d", i), 32'(vcAtWrA[base + i]), 32'd4);
        enA = 1'b0;
        period = 1;
        @(negedge clk);

        // 5) abort in the middle of the second window, then restart
        $display("[TB] test 5: abort and restart");
        base = wrDataA.size();
        enA = 1'b1;
        waitFor(3, 50, hit);
        checkOutput("t5_first_wr", 32'(hit), 32'd1);
        n = 0;
        for (int i = 0; i < 20 && n < 2; i++) begin
            @(negedge clk);
            if (validA) n++;
        end
        enA = 1'b0;
        @(negedge clk);
        checkOutput("t5_idle_rd", 32'(rdA), 32'd0);
        checkOutput("t5_idle_wr", 32'(wrA), 32'd0);
        repeat (4) @(negedge clk);
        checkOutput("t5_no_write", 32'(wrDataA.size() - base), 32'd1);
        base = wrDataA.size();
        enA = 1'b1;
        @(negedge clk);
        checkOutput("t5_restart_rd", 32'(rdA), 32'd1);
        checkOutput("t5_restart_addr", 32'(addrInA), 32'd0);
        applyStimulus(0);
        checkFourA("t5", base, 32'h0006_0000, 32'h0008_0000, 32'h000E_0000, 32'h0010_0000);
        enA = 1'b0;
        @(negedge clk);

        // 6a) async reset during WR
        $display("[TB] test 6: async reset in WR");
        enA = 1'b1;
        waitFor(3, 50, hit);
        checkOutput("t6_wr_seen", 32'(hit), 32'd1);
        #1 rst = 1'b1;
        #1;
        checkOutput("t6_wr", 32'(wrA), 32'd0);
        checkOutput("t6_done", 32'(doneA), 32'd0);
        checkOutput("t6_dout", dataOutA, 32'd0);
        checkOutput("t6_aout", 32'(addrOutA), 32'd0);
        enA = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 4) odd 5x5x2 map
        $display("[TB] test 4: 5x5x2 odd map");
        enB = 1'b1;
        applyStimulus(1);
        checkOutput("t4_count", 32'(wrDataB.size()), 32'd8);
        begin
            logic [31:0] expB [8];
            expB = '{32'd6, 32'd8, 32'd16, 32'd18, 32'd31, 32'd33, 32'd41, 32'd43};
            for (int i = 0; i < 8 && i < wrDataB.size(); i++) begin
                checkOutput($sformatf("t4_data%0d", i), wrDataB[i], expB[i] << 16);
                checkOutput($sformatf("t4_addr%0d", i), 32'(wrAddrB[i]), 32'(OUT_BASE) + 32'(i));
            end
        end
        checkOutput("t4_no_col_row4", 32'(badAddrB), 32'd0);
        checkOutput("t4_ch1_start", (rdLogB.size() > 16) ? 32'(rdLogB[16]) : 32'hFFFF_FFFF, 32'd25);
        enB = 1'b0;
        @(negedge clk);

        // 6b) default 28x28x6 run against the bench model
        $display("[TB] test 6: default 28x28x6 run");
        enC = 1'b1;
        applyStimulus(2);
        checkOutput("t6_full_count", 32'(wrDataC.size()), 32'd1176);
        checkOutput("t6_full_done", 32'(doneC), 32'd1);
        for (int i = 0; i < 1176 && i < wrDataC.size(); i++) begin
            checkOutput($sformatf("t6_full_data%0d", i), wrDataC[i], expC[i]);
            checkOutput($sformatf("t6_full_addr%0d", i), 32'(wrAddrC[i]), 32'(OUT_BASE) + 32'(i));
        end
        checkOutput("rd_wr_overlap", 32'(overlapA + overlapC), 32'd0);
        enC = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
